// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the transmitter and the oversampling receiver.
//   BPS_*      3-bit baud-select encodings
//   rx_state_e receiver FSM states
//   baud_div   16x-oversample divider, round(clk_freq / (16 * baud))
package uart_pkg;

    localparam logic [2:0] BPS_1200   = 3'd0;
    localparam logic [2:0] BPS_2400   = 3'd1;
    localparam logic [2:0] BPS_4800   = 3'd2;
    localparam logic [2:0] BPS_9600   = 3'd3;
    localparam logic [2:0] BPS_19200  = 3'd4;
    localparam logic [2:0] BPS_38400  = 3'd5;
    localparam logic [2:0] BPS_57600  = 3'd6;
    localparam logic [2:0] BPS_115200 = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_e;

    function automatic logic [15:0] baud_div(input int unsigned clk_freq, input logic [2:0] bps_sel);
        int unsigned baud;
        case (bps_sel)
            BPS_1200:  baud = 1200;
            BPS_2400:  baud = 2400;
            BPS_4800:  baud = 4800;
            BPS_9600:  baud = 9600;
            BPS_19200: baud = 19200;
            BPS_38400: baud = 38400;
            BPS_57600: baud = 57600;
            default:   baud = 115200;
        endcase
        return 16'((clk_freq + 8 * baud) / (16 * baud));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator with synchronous clear.
//   clk_i, rst_ni  clock, synchronous active-low reset
//   clr_i          holds counter and tick index at 0
//   div_i          clocks per oversample tick
//   tick_o         one-cycle pulse when the counter reaches div_i-1
//   idx_o          index (0..15) of the tick within the current bit
module uart_baud_tick (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic [15:0] div_i,
    output logic        tick_o,
    output logic [3:0]  idx_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;

    always_comb begin
        tick_o = !clr_i && (cnt_q == div_i - 16'd1);
        cnt_d  = (clr_i || tick_o) ? 16'd0 : cnt_q + 16'd1;
        idx_d  = clr_i ? 4'd0 : idx_q + 4'(tick_o);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: 16x oversampling UART receiver (8 data bits, optional even parity, 1 stop).
//   CLK, rst_n   clock, synchronous active-low reset
//   rx           asynchronous serial line, idle high
//   bps_sel      baud select (uart_pkg BPS_*), latched at start detection
//   check_sel    1 = even parity bit present, latched at start detection
//   dout         last received byte, held until the next dout_vld
//   dout_vld     one-cycle pulse per received frame
//   error        parity or framing error, only set with dout_vld
//   busy         high from start detection until return to idle
// Build option UART_RX_MAJORITY_EN: bit value is the 2-of-3 majority of ticks 7/8/9.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [2:0] bps_sel,
    input  logic       check_sel,
    output logic [7:0] dout,
    output logic       dout_vld,
    output logic       error,
    output logic       busy
);

    rx_state_e   state_q, state_d;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [2:0]  bps_q;
    logic        par_en_q;
    logic [7:0]  shift_q;
    logic [2:0]  cnt_q;
    logic        bit_q;
    logic        par_err_q;
    logic [7:0]  dout_q;
    logic        vld_q, err_q;
    logic        tick, clr;
    logic [3:0]  idx;
    logic        fall, smp, bit_end, bit_val, start_det, stop_det;

    assign fall      = rx_prev_q & ~rx_s2_q;
    assign bit_end   = tick && idx == 4'd15;
    assign start_det = state_q == S_IDLE && fall;
    assign stop_det  = state_q == S_STOP && smp;

`ifdef UART_RX_MAJORITY_EN
    logic s7_q, s8_q;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            s7_q <= 1'b1;
            s8_q <= 1'b1;
        end else begin
            if (tick && idx == 4'd7) s7_q <= rx_s2_q;
            if (tick && idx == 4'd8) s8_q <= rx_s2_q;
        end
    end

    // Decision lands on tick 9, with the tick-9 sample taken live.
    assign smp     = tick && idx == 4'd9;
    assign bit_val = (s7_q & s8_q) | (s7_q & rx_s2_q) | (s8_q & rx_s2_q);
`else
    assign smp     = tick && idx == 4'd8;
    assign bit_val = rx_s2_q;
`endif

    uart_baud_tick u_tick (
        .clk_i  (CLK),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .div_i  (baud_div(CLK_FREQ, bps_q)),
        .tick_o (tick),
        .idx_o  (idx)
    );

    always_ff @(posedge CLK) begin
        state_q <= !rst_n ? S_IDLE : state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = fall ? S_START : S_IDLE;
            S_START:  state_d = (smp && bit_val) ? S_IDLE : bit_end ? S_DATA : S_START;
            S_DATA:   state_d = (bit_end && cnt_q == 3'd7) ? (par_en_q ? S_PARITY : S_STOP) : S_DATA;
            S_PARITY: state_d = bit_end ? S_STOP : S_PARITY;
            S_STOP:   state_d = smp ? S_IDLE : S_STOP;
            default:  state_d = S_IDLE;
        endcase
    end

    // Counter is held cleared while idle, so it starts from 0 on the start edge.
    always_comb begin
        busy = state_q != S_IDLE;
        clr  = state_q == S_IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            bps_q     <= '0;
            par_en_q  <= 1'b0;
            shift_q   <= '0;
            cnt_q     <= '0;
            bit_q     <= 1'b0;
            par_err_q <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
            vld_q     <= stop_det;
            err_q     <= stop_det && (par_err_q || !bit_val);
            if (start_det) begin
                bps_q     <= bps_sel;
                par_en_q  <= check_sel;
                cnt_q     <= '0;
                par_err_q <= 1'b0;
            end
            if (smp) bit_q <= bit_val;
            if (state_q == S_DATA && bit_end) begin
                shift_q <= {bit_q, shift_q[7:1]};
                cnt_q   <= cnt_q + 3'd1;
            end
            if (state_q == S_PARITY && smp) par_err_q <= bit_val ^ (^shift_q);
            if (stop_det) dout_q <= shift_q;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign error    = err_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// tb_uart_rx_oversample: scoreboard bench for uart_rx_oversample at 50 MHz.
module tb_uart_rx_oversample;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] bps_sel = 3'd4;
    logic       check_sel = 1'b1;
    logic [7:0] dout;
    logic       dout_vld, error, busy;

    int errors = 0;
    int checks = 0;
    int vld_cnt = 0;
    int push_cnt = 0;
    int busy_cnt = 0;
    int stray_cnt = 0;
    int div = 163;
    int bit_cyc = 163 * 16;
    logic [8:0] exp_q [$];

    uart_rx_oversample #(.CLK_FREQ(50_000_000)) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .rx        (rx),
        .bps_sel   (bps_sel),
        .check_sel (check_sel),
        .dout      (dout),
        .dout_vld  (dout_vld),
        .error     (error),
        .busy      (busy)
    );

    always #10 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [8:0] e;
        @(negedge CLK);
        if (busy) busy_cnt++;
        if (error && !dout_vld) stray_cnt++;
        if (dout_vld) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                check("spurious_vld", 32'(dout_vld), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("dout", 32'(dout), 32'(e[7:0]));
                check("error", 32'(error), 32'(e[8]));
                check("busy_drop", 32'(busy), 32'd0);
            end
        end
    endtask

    task automatic hold(input logic v, input int bits);
        rx = v;
        for (int c = 0; c < bits * bit_cyc; c++) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"}, 32'(dout), 32'd0);
        check({tag, "_vld"}, 32'(dout_vld), 32'd0);
        check({tag, "_err"}, 32'(error), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // act: 0 none, 1 one-cycle reset at act_at, 2 change config at act_at,
    // 3 invert rx for one tick starting at act_at
    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par,
                              input logic stop, input logic push, input int act_at, input int act);
        logic [10:0] bits;
        int n, k;
        bits = par_en ? {stop, par, d, 1'b0} : {1'b1, stop, d, 1'b0};
        n = par_en ? 11 : 10;
        if (push) begin
            exp_q.push_back({(par_en && (par ^ (^d))) || !stop, d});
            push_cnt++;
        end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < bit_cyc; c++) begin
                k = i * bit_cyc + c;
                rx = (act == 3 && k >= act_at && k < act_at + div) ? ~bits[i] : bits[i];
                if (k == act_at && act == 1) begin
                    rst_n = 1'b0;
                    step();
                    check_reset_outputs("midreset");
                    rst_n = 1'b1;
                end
                if (k == act_at && act == 2) begin
                    bps_sel = 3'd0;
                    check_sel = ~check_sel;
                end
                step();
            end
        end
    endtask

    initial begin
        int b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, -1, 0);
        hold(1'b1, 1);
        check("busy_idle", 32'(busy), 32'd0);

        bps_sel = 3'd7;
        div = 27;
        bit_cyc = 27 * 16;
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, -1, 0);
        hold(1'b1, 1);

        check_sel = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0);
        hold(1'b0, 2);
        hold(1'b1, 2);
        check("break_frames", 32'(vld_cnt), 32'd3);

        b0 = busy_cnt;
        rx = 1'b0;
        repeat (4 * div) step();
        hold(1'b1, 2);
        check("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
        check("glitch_idle", 32'(busy), 32'd0);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, (16 * 3 + 8) * div + div / 2, 3);
        hold(1'b1, 1);
`endif

        send_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 3 * bit_cyc, 2);
        bps_sel = 3'd7;
        check_sel = 1'b0;
        hold(1'b1, 1);

        send_frame(8'hF8, 1'b0, 1'b0, 1'b1, 1'b0, 4 * bit_cyc + bit_cyc / 2, 1);
        hold(1'b1, 1);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, -1, 0);
        hold(1'b1, 2);

        check("pending", 32'(exp_q.size()), 32'd0);
        check("vld_count", 32'(vld_cnt), 32'(push_cnt));
        check("stray_error", 32'(stray_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
